vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate enable, h/v counters, sync pulses,
// visible-area flag and pixel coordinates for a VGA-style display.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_tick,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit bounds so a total of exactly 1024 still compares correctly
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic        ACT_LVL  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_check
        $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end

    function automatic logic in_window(input logic [9:0] pos,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        in_window = ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

    logic       w_tick;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;

    if (CLK_DIV == 1) begin : g_nodiv
        assign w_tick = 1'b1;
    end else begin : g_div
        localparam int DIV_W = $clog2(CLK_DIV);
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
        logic [DIV_W-1:0] r_div_cnt;

        // Pixel-rate divider, wraps at CLK_DIV-1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_div_cnt <= DIV_W'(0);
            end else if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= DIV_W'(0);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end

        assign w_tick = (r_div_cnt == DIV_LAST);
    end

    // Next-state horizontal/vertical position
    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (w_tick) begin
            if (r_h == H_LAST) begin
                w_h_next = 10'd0;
                if (r_v == V_LAST) begin
                    w_v_next = 10'd0;
                end else begin
                    w_v_next = r_v + 10'd1;
                end
            end else begin
                w_h_next = r_h + 10'd1;
                w_v_next = r_v;
            end
        end else begin
            w_h_next = r_h;
            w_v_next = r_v;
        end
    end

    // Counters plus syncs/video_on derived from next state so all change together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h        <= 10'd0;
            r_v        <= 10'd0;
            r_hsync    <= ~ACT_LVL;
            r_vsync    <= ~ACT_LVL;
            r_video_on <= 1'b1;
        end else begin
            r_h        <= w_h_next;
            r_v        <= w_v_next;
            r_hsync    <= in_window(w_h_next, HS_START, HS_END) ? ACT_LVL : ~ACT_LVL;
            r_vsync    <= in_window(w_v_next, VS_START, VS_END) ? ACT_LVL : ~ACT_LVL;
            r_video_on <= ({1'b0, w_h_next} < H_VIS) && ({1'b0, w_v_next} < V_VIS);
        end
    end

    assign x           = r_h;
    assign y           = r_v;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_tick  = w_tick;
    assign frame_start = w_tick && (r_h == H_LAST) && (r_v == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-geometry instances (divide-by-4 active-low,
// divide-by-1 active-high) checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;
    localparam int D0 = 4;
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 5;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk;
    logic       reset;
    logic       hs0, vs0, vid0, tick0, fs0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, vid1, tick1, fs1;
    logic [9:0] x1, y1;

    int n_eval;
    int n_fail;
    int n;

    vga_timing_gen #(
        .CLK_DIV(D0), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut0 (
        .clk(clk), .reset(reset), .hsync(hs0), .vsync(vs0), .video_on(vid0),
        .x(x0), .y(y0), .pixel_tick(tick0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
    ) dut1 (
        .clk(clk), .reset(reset), .hsync(hs1), .vsync(vs1), .video_on(vid1),
        .x(x1), .y(y1), .pixel_tick(tick1), .frame_start(fs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_eval++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Model: n edges since reset release -> pixel index n/d -> raster position
    task automatic check_dut(input string nm, input int d, input logic pol,
                             input logic [9:0] ox, input logic [9:0] oy,
                             input logic ohs, input logic ovs, input logic ovid,
                             input logic otick, input logic ofs);
        int p, h, v;
        logic et, ehs, evs;
        p   = n / d;
        h   = p % HT;
        v   = (p / HT) % VT;
        et  = ((n % d) == d - 1);
        ehs = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
        evs = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
        chk({nm, ".x"}, 32'(ox), h);
        chk({nm, ".y"}, 32'(oy), v);
        chk({nm, ".hsync"}, 32'(ohs), 32'(ehs));
        chk({nm, ".vsync"}, 32'(ovs), 32'(evs));
        chk({nm, ".video_on"}, 32'(ovid), 32'((h < HA) && (v < VA)));
        chk({nm, ".pixel_tick"}, 32'(otick), 32'(et));
        chk({nm, ".frame_start"}, 32'(ofs), 32'(et && h == HT - 1 && v == VT - 1));
    endtask

    task automatic check_all();
        check_dut("d0", D0, 1'b0, x0, y0, hs0, vs0, vid0, tick0, fs0);
        check_dut("d1", 1, 1'b1, x1, y1, hs1, vs1, vid1, tick1, fs1);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            if (reset) n++;
            @(negedge clk);
            check_all();
        end
    endtask

    // Called just after a negedge: reset asserts between edges, takes effect at once
    task automatic do_reset(input int hold);
        #($urandom_range(1, 2));
        reset = 1'b0;
        n = 0;
        #1;
        check_all();
        run(hold);
        #1 reset = 1'b1;
    endtask

    initial begin
        int c_fs0, c_vid0, c_hs0, c_vs0, c_fs1, c_vid1, c_hs1, c_vs1;
        n_eval = 0;
        n_fail = 0;
        n      = 0;
        reset  = 1'b0;

        run(10);
        chk("rst_hsync0", 32'(hs0), 32'd1);
        chk("rst_hsync1", 32'(hs1), 32'd0);
        chk("rst_tick1_const", 32'(tick1), 32'd1);
        #1 reset = 1'b1;

        run(3);
        chk("first_tick_clk3", 32'(tick0), 32'd1);
        chk("x_before_4th", 32'(x0), 32'd0);
        run(1);
        chk("x_after_4th", 32'(x0), 32'd1);

        // Whole-frame tallies from a fresh reset
        do_reset(3);
        c_fs0 = 0; c_vid0 = 0; c_hs0 = 0; c_vs0 = 0;
        c_fs1 = 0; c_vid1 = 0; c_hs1 = 0; c_vs1 = 0;
        for (int i = 0; i < HT * VT * D0; i++) begin
            run(1);
            c_fs0 += int'(fs0);  c_vid0 += int'(vid0);
            c_hs0 += int'(!hs0); c_vs0  += int'(!vs0);
            c_fs1 += int'(fs1);  c_vid1 += int'(vid1);
            c_hs1 += int'(hs1);  c_vs1  += int'(vs1);
        end
        chk("frame_start_count0", c_fs0, 1);
        chk("video_clks0", c_vid0, HA * VA * D0);
        chk("hsync_clks0", c_hs0, HS * VT * D0);
        chk("vsync_clks0", c_vs0, VS * HT * D0);
        chk("frame_start_count1", c_fs1, D0);
        chk("video_clks1", c_vid1, HA * VA * D0);
        chk("hsync_clks1", c_hs1, HS * VT * D0);
        chk("vsync_clks1", c_vs1, VS * HT * D0);

        // Mid-frame reset inside an hsync pulse
        do_reset(1);
        run((3 * HT + HA + HF + 1) * D0 + 1);
        chk("mid_x", 32'(x0), HA + HF + 1);
        chk("mid_y", 32'(y0), 3);
        chk("mid_in_hsync", 32'(hs0), 32'd0);
        do_reset(3);
        run(HT * D0 * 2);

        repeat (8) begin
            run($urandom_range(20, 700));
            do_reset($urandom_range(1, 6));
        end
        run(2 * HT * VT * D0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
